modexp_regbank_ctrl: RTL and testbench

Parametrised host-side register bank and sequencer for the modular-exponentiation datapath.
- Holds NUM_REGS operand registers of REG_W bits, with byte-wide host write/read access.
- Launches an external compute engine with a start/done handshake and writes its result back into register 0.
- Generalises the fixed 4x256-bit front end: parametrised width and depth, registered read port, busy-write error reporting, re-arm protection on start, optional watchdog.

---
 rtl/modexp_regbank_pkg.sv | 19 +
 rtl/modexp_regbank_wd.sv | 40 ++++
 rtl/modexp_regbank_ctrl.sv | 153 +++++++++++++++
 tb/tb_modexp_regbank_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modexp_regbank_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | modexp_regbank_pkg: shared FSM state and constants for the regbank ctrl. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package modexp_regbank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int RESULT_IDX = 0;
  localparam int BYTE_W     = 8;

endpackage
`default_nettype wire

// File: rtl/modexp_regbank_wd.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | modexp_regbank_wd: WAIT-state cycle counter; expired after TIMEOUT cycles.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module modexp_regbank_wd #(
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Expiry fires during the TIMEOUT-th enabled cycle, when the count is about to reach TIMEOUT.
  assign expired = enable && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/modexp_regbank_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | modexp_regbank_ctrl: byte-access operand bank + start/done engine        |
// | sequencer. Optional watchdog: MODEXP_REGBANK_WATCHDOG_EN.     Rev 1.0    |
// +--------------------------------------------------------------------------+
module modexp_regbank_ctrl
  import modexp_regbank_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int REG_W    = 256,
  parameter int SEL_W    = $clog2(NUM_REGS),
  parameter int ADDR_W   = $clog2(REG_W / 8),
  parameter int TIMEOUT  = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      we,
  input  logic                      oe,
  input  logic                      start,
  input  logic [SEL_W-1:0]          reg_sel,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [7:0]                data_i,
  output logic [7:0]                data_o,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      eng_start,
  output logic [NUM_REGS*REG_W-1:0] eng_operands,
  input  logic                      eng_done,
  input  logic [REG_W-1:0]          eng_result
);

  localparam int NUM_BYTES = REG_W / BYTE_W;

  generate
    if (NUM_REGS < 2 || (REG_W % BYTE_W) != 0 || TIMEOUT < 1) begin : g_bad_params
      $error("modexp_regbank_ctrl: illegal parameter set");
    end
  endgenerate

  state_e              state_q, state_d;
  logic [REG_W-1:0]    regs_q [NUM_REGS];
  logic [BYTE_W-1:0]   data_o_q, data_o_d;
  logic                err_q, err_d;
  logic                armed_q, armed_d;
  logic                sel_ok, addr_ok, wr_en, rd_en, launch, wd_expired;
  logic [BYTE_W-1:0]   rd_byte;

  assign sel_ok  = int'(reg_sel) < NUM_REGS;
  assign addr_ok = int'(addr) < NUM_BYTES;
  assign wr_en   = (state_q == ST_IDLE) && !we;
  assign rd_en   = (state_q == ST_IDLE) && we && !oe;
  assign launch  = (state_q == ST_IDLE) && we && oe && !start && armed_q;
  assign rd_byte = regs_q[reg_sel][addr*BYTE_W +: BYTE_W];

`ifdef MODEXP_REGBANK_WATCHDOG_EN
  modexp_regbank_wd #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == ST_LAUNCH),
    .enable  (state_q == ST_WAIT),
    .expired (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (launch) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (eng_done) begin
          state_d = ST_DONE;
        end else if (wd_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    eng_start = (state_q == ST_LAUNCH);
    done      = (state_q == ST_DONE);
  end

  always_comb begin
    data_o_d = (rd_en && sel_ok && addr_ok) ? rd_byte : '0;

    armed_d = armed_q;
    if (start) begin
      armed_d = 1'b1;
    end else if (launch) begin
      armed_d = 1'b0;
    end

    // A host write attempted outside IDLE is dropped and flagged.
    err_d = err_q;
    if (launch) begin
      err_d = 1'b0;
    end else if (!we && state_q != ST_IDLE) begin
      err_d = 1'b1;
    end else if (state_q == ST_WAIT && !eng_done && wd_expired) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      data_o_q <= '0;
      err_q    <= 1'b0;
      armed_q  <= 1'b1;
    end else begin
      if (wr_en && sel_ok && addr_ok) begin
        regs_q[reg_sel][addr*BYTE_W +: BYTE_W] <= data_i;
      end
      if (state_q == ST_WAIT && eng_done) begin
        regs_q[RESULT_IDX] <= eng_result;
      end
      data_o_q <= data_o_d;
      err_q    <= err_d;
      armed_q  <= armed_d;
    end
  end

  assign data_o = data_o_q;
  assign err    = err_q;

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_ops
      assign eng_operands[i*REG_W +: REG_W] = regs_q[i];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_modexp_regbank_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_modexp_regbank_ctrl: self-checking bench for modexp_regbank_ctrl.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_modexp_regbank_ctrl;

  localparam int NR   = 4;
  localparam int RW   = 256;
  localparam int SW   = 2;
  localparam int AW   = 5;
  localparam int TO   = 16;
  localparam int MAXC = 300;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          we = 1'b1, oe = 1'b1, start = 1'b1, eng_done = 1'b0;
  logic [SW-1:0] reg_sel = '0;
  logic [AW-1:0] addr = '0;
  logic [7:0]    data_i = '0;
  logic [7:0]    data_o;
  logic          busy, done, err, eng_start;
  logic [NR*RW-1:0] eng_operands;
  logic [RW-1:0] eng_result = '0;

  always #5 clk = ~clk;

  modexp_regbank_ctrl #(
    .NUM_REGS (NR),
    .REG_W    (RW),
    .TIMEOUT  (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .we           (we),
    .oe           (oe),
    .start        (start),
    .reg_sel      (reg_sel),
    .addr         (addr),
    .data_i       (data_i),
    .data_o       (data_o),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .eng_start    (eng_start),
    .eng_operands (eng_operands),
    .eng_done     (eng_done),
    .eng_result   (eng_result)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [RW-1:0] mdl [NR];
  logic [7:0]    exp_q [$];
  logic [7:0]    mon_e;

  typedef struct {
    bit         rd;
    int         s;
    int         a;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_ops(input string nm);
    for (int r = 0; r < NR; r++) chk(nm, eng_operands[r*RW +: RW], mdl[r]);
  endtask

  // Read scoreboard: expectations queued at drive time, compared one cycle later.
  initial forever begin
    @(posedge clk);
    if (!reset && we && !oe) begin
      chk("rd_expected_queued", RW'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        @(negedge clk);
        chk("rd_data", data_o, mon_e);
      end
    end
  end

  task automatic do_write(input int s, input int a, input logic [7:0] d);
    @(negedge clk);
    we = 1'b0; reg_sel = SW'(s); addr = AW'(a); data_i = d;
    @(negedge clk);
    we = 1'b1;
    mdl[s][a*8 +: 8] = d;
  endtask

  task automatic do_read(input int s, input int a, input logic [7:0] e);
    @(negedge clk);
    oe = 1'b0; reg_sel = SW'(s); addr = AW'(a);
    exp_q.push_back(e);
    @(negedge clk);
    oe = 1'b1;
  endtask

  // Launch and act as the engine: eng_done is driven lat+1 WAIT cycles after eng_start.
  // poke_at>0 injects a busy write at that WAIT cycle and a busy read two cycles later.
  task automatic run_launch(input int lat, input logic [RW-1:0] res, input bit hold,
                            input int poke_at, output int busy_n, output int es_n,
                            output int done_n);
    int w;
    bit active, seen;
    busy_n = 0; es_n = 0; done_n = 0; w = 0; active = 0; seen = 0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < MAXC; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b1;
      eng_done = 1'b0; we = 1'b1; oe = 1'b1;
      busy_n += int'(busy);
      es_n   += int'(eng_start);
      done_n += int'(done);
      if (seen && !busy) break;
      if (done) seen = 1;
      if (active) begin
        w++;
        if (poke_at > 0 && w == poke_at) begin
          we = 1'b0; reg_sel = SW'(1); addr = '0; data_i = 8'hFF;
        end
        if (poke_at > 0 && w == poke_at + 2) begin
          oe = 1'b0; reg_sel = SW'(1); addr = '0;
          exp_q.push_back(8'h00);
        end
        if (w == lat + 1) begin
          eng_done = 1'b1; eng_result = res; active = 0;
        end
      end
      if (eng_start) begin
        active = 1; w = 0;
      end
    end
    eng_done = 1'b0; we = 1'b1; oe = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int b, e, d;
    for (int r = 0; r < NR; r++) mdl[r] = '0;
    tbl[0]  = '{0, 2, 3,  8'hA5, 8'h00};
    tbl[1]  = '{1, 2, 3,  8'h00, 8'hA5};
    tbl[2]  = '{1, 2, 2,  8'h00, 8'h00};
    tbl[3]  = '{0, 1, 0,  8'h5A, 8'h00};
    tbl[4]  = '{0, 3, 31, 8'hC3, 8'h00};
    tbl[5]  = '{1, 3, 31, 8'h00, 8'hC3};
    tbl[6]  = '{1, 1, 0,  8'h00, 8'h5A};
    tbl[7]  = '{0, 0, 5,  8'h77, 8'h00};
    tbl[8]  = '{1, 0, 5,  8'h00, 8'h77};
    tbl[9]  = '{1, 1, 1,  8'h00, 8'h00};
    tbl[10] = '{0, 2, 0,  8'h11, 8'h00};
    tbl[11] = '{1, 2, 0,  8'h00, 8'h11};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_data_o", data_o, 0);
    chk_ops("rst_ops");

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].rd) do_read(tbl[i].s, tbl[i].a, tbl[i].exp);
      else do_write(tbl[i].s, tbl[i].a, tbl[i].wdata);
    end
    @(negedge clk);
    chk("ops_r2_b3", eng_operands[2*256+24 +: 8], 8'hA5);
    chk_ops("ops_after_writes");

    // Write beats read when both strobes are low.
    @(negedge clk);
    we = 1'b0; oe = 1'b0; reg_sel = SW'(3); addr = AW'(1); data_i = 8'h3C;
    @(negedge clk);
    we = 1'b1; oe = 1'b1;
    mdl[3][15:8] = 8'h3C;
    chk("wr_rd_prio_data_o", data_o, 0);
    do_read(3, 1, 8'h3C);

    run_launch(10, 256'h1234, 0, 0, b, e, d);
    mdl[0] = 256'h1234;
    chk("t2_busy_cycles", b, 13);
    chk("t2_eng_start_pulses", e, 1);
    chk("t2_done_pulses", d, 1);
    do_read(0, 0, 8'h34);
    do_read(0, 1, 8'h12);
    chk_ops("t2_ops");

    run_launch(10, 256'h55AA, 0, 3, b, e, d);
    mdl[0] = 256'h55AA;
    chk("t3_busy_cycles", b, 13);
    chk("t3_err_set", err, 1);
    do_read(1, 0, 8'h5A);
    chk_ops("t3_ops");
    run_launch(4, 256'h77, 0, 0, b, e, d);
    mdl[0] = 256'h77;
    chk("t3_err_cleared", err, 0);
    chk("t3b_busy_cycles", b, 7);

    run_launch(6, 256'hC0DE, 1, 0, b, e, d);
    mdl[0] = 256'hC0DE;
    chk("t4_hold_eng_start", e, 1);
    chk("t4_hold_done", d, 1);
    e = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e += int'(eng_start);
    end
    chk("t4_no_relaunch", e, 0);
    chk("t4_idle", busy, 0);
    @(negedge clk);
    start = 1'b1;
    run_launch(2, 256'hF00D, 0, 0, b, e, d);
    mdl[0] = 256'hF00D;
    chk("t4_rearm_eng_start", e, 1);
    chk("t4_rearm_busy", b, 5);
    chk_ops("t4_ops");

    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    chk("t5_launch", eng_start, 1);
    repeat (3) @(negedge clk);
    chk("t5_in_wait", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; eng_done = 1'b1; eng_result = 256'hBEEF;
    b = 0; d = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      eng_done = 1'b0;
      b += int'(busy);
      d += int'(done);
    end
    for (int r = 0; r < NR; r++) mdl[r] = '0;
    chk("t5_busy", b, 0);
    chk("t5_done", d, 0);
    chk("t5_err", err, 0);
    chk_ops("t5_ops");
    do_read(0, 0, 8'h00);
    do_read(0, 1, 8'h00);

    do_write(0, 0, 8'h99);
    b = 0; d = 0;
    @(negedge clk);
    start = 1'b0;
`ifdef MODEXP_REGBANK_WATCHDOG_EN
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      start = 1'b1;
      b += int'(busy);
      d += int'(done);
    end
    chk("t6_busy_cycles", b, 1 + TO);
    chk("t6_done", d, 0);
    chk("t6_err", err, 1);
    chk("t6_idle", busy, 0);
    chk_ops("t6_ops");
`else
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      start = 1'b1;
      b += int'(busy);
      d += int'(done);
    end
    chk("t6_busy_cycles", b, 100);
    chk("t6_done", d, 0);
    chk_ops("t6_ops");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < NR; r++) mdl[r] = '0;
    chk("t6_reset_idle", busy, 0);
    chk_ops("t6_reset_ops");
`endif

    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
